perf_counter_controller: RTL
============================

Name: perf_counter_controller

Overview:
Programmable front end for the core's event counters. Holds per-counter event-select and control registers, gates and counts selected events into 64-bit counters, and exposes them over a 32-bit control-register interface. Provides a coherent two-word 64-bit read through a high-word snapshot, and raises an interrupt on low-word wrap. Sits beside the control-register unit; event lines come from pipeline and cache modules.

Parameters:
NUM_EVENTS, 8, number of event input lines
EVENT_IDX_WIDTH, $clog2(NUM_EVENTS), width of an event select field
NUM_COUNTERS, 2, number of counters (1..15)
ADDR_WIDTH, 6, control-register word address width; must hold NUM_COUNTERS*4+1

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
perf_events  in  NUM_EVENTS  per-cycle event pulses, bit i = event i
cr_write_en  in  1  register write strobe
cr_read_en  in  1  register read strobe
cr_addr  in  ADDR_WIDTH  word address
cr_write_data  in  32  write data
cr_read_data  out  32  read data, valid when cr_read_valid
cr_read_valid  out  1  read response strobe
perf_irq  out  1  OR of (irq_status & irq_enable) over counters

Behaviour:
- Single clock clk; reset is synchronous, active-high, sampled on posedge clk.
- Register map, counter n at base 4n: +0 SELECT (bits EVENT_IDX_WIDTH-1:0, RW); +1 CTRL (bit0 enable, bit1 irq_enable, RW, other bits read 0); +2 COUNT_LO (read: count[31:0] and capture count[63:32] into snapshot_hi[n]; write: clear count to 0); +3 COUNT_HI (read: snapshot_hi[n]; write ignored).
- Address 4*NUM_COUNTERS: IRQ_STATUS, bit n per counter, write-1-to-clear. Other addresses: writes ignored, reads return 0.
- Reset: all counts, SELECT, CTRL, snapshots, irq_status = 0; cr_read_data = 0; cr_read_valid = 0; perf_irq = 0.
- Counting: each cycle, if CTRL.enable[n] and perf_events[SELECT[n]], count[n] <= count[n]+1, modulo 2^64. SELECT values >= NUM_EVENTS count nothing.
- Read latency: exactly 1 cycle. cr_read_valid is high the cycle after cr_read_en; cr_read_data holds registered pre-increment values from the request cycle. cr_read_data keeps its last value when cr_read_valid = 0.
- Snapshot: COUNT_LO read captures count[63:32] in the same cycle as the low word, so LO-then-HI yields a coherent 64-bit value despite a carry between the reads.
- Wrap IRQ: when an increment takes count[31:0] from 0xFFFFFFFF to 0, set irq_status[n] regardless of irq_enable. perf_irq is registered and asserts the cycle after status or enable changes.
- Simultaneous events:
  - COUNT_LO write (clear) and increment in the same cycle: clear wins, count = 0.
  - IRQ_STATUS W1C and wrap set in the same cycle: set wins.
  - SELECT or CTRL write takes effect on events starting the next cycle.
  - Read and write in the same cycle: read returns pre-write value.
- Reset mid-operation clears everything; no read response is issued for a read requested in the reset cycle.
- No backpressure: one access per strobe, and both strobes may be high together.

Test Plan:
- Reset, then read every defined address -> cr_read_valid one cycle after each cr_read_en, all data 0, perf_irq = 0.
- SELECT0 = 3, CTRL0 = 1, pulse perf_events[3] 10 times and perf_events[2] 5 times -> COUNT_LO0 = 10, COUNT_HI0 = 0, counter 1 = 0.
- Preload count0 = 0x0000_0000_FFFF_FFFE via increments, CTRL0 = 3, two events -> count 0x1_0000_0000, irq_status = 1, perf_irq high next cycle; write IRQ_STATUS = 1 -> perf_irq low.
- count0 = 0xFFFF_FFFF, read COUNT_LO, event next cycle, then read COUNT_HI -> returns 0xFFFF_FFFF then 0 (snapshot), not 1.
- Write COUNT_LO0 in the same cycle as a selected event -> subsequent read returns 0. Write IRQ_STATUS in the same cycle as a wrap -> status remains 1.
- Read address 4*NUM_COUNTERS+1 -> data 0. Assert reset during counting -> all registers 0 on the next read.

Source files
------------

// File: rtl/perf_counter_controller.sv
// Event-counter front end: per-counter event select/control, 64-bit counters, 32-bit CR access, wrap IRQ.
// Latency: register reads respond exactly one cycle after cr_read_en; writes take effect at the next edge.
// Backpressure: none; every strobe is serviced, and read and write may be issued in the same cycle.
module perf_counter_controller #(
  parameter int NUM_EVENTS      = 8,
  parameter int EVENT_IDX_WIDTH = $clog2(NUM_EVENTS),
  parameter int NUM_COUNTERS    = 2,
  parameter int ADDR_WIDTH      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] perf_events,
  input  logic                  cr_write_en,
  input  logic                  cr_read_en,
  input  logic [ADDR_WIDTH-1:0] cr_addr,
  input  logic [31:0]           cr_write_data,
  output logic [31:0]           cr_read_data,
  output logic                  cr_read_valid,
  output logic                  perf_irq
);

  localparam logic [ADDR_WIDTH-1:0] IRQ_ADDR = ADDR_WIDTH'(4 * NUM_COUNTERS);

  logic [NUM_COUNTERS-1:0][63:0]                count;
  logic [NUM_COUNTERS-1:0][EVENT_IDX_WIDTH-1:0] sel;
  logic [NUM_COUNTERS-1:0][31:0]                snap_hi;
  logic [NUM_COUNTERS-1:0]                      ctrl_en;
  logic [NUM_COUNTERS-1:0]                      irq_en;
  logic [NUM_COUNTERS-1:0]                      irq_status;

  // Per-counter decoded strobes and event qualification
  logic [NUM_COUNTERS-1:0] wr_sel, wr_ctrl, wr_clr, rd_lo, inc, wrap;
  logic                    wr_irq;
  logic [31:0]             rd_mux;

  // Address decode, increment qualification and low-word wrap detection
  always_comb begin
    wr_sel = '0;
    wr_ctrl = '0;
    wr_clr = '0;
    rd_lo = '0;
    inc = '0;
    wrap = '0;
    wr_irq = cr_write_en && (cr_addr == IRQ_ADDR);
    for (int n = 0; n < NUM_COUNTERS; n++) begin
      wr_sel[n]  = cr_write_en && (cr_addr == ADDR_WIDTH'(4 * n));
      wr_ctrl[n] = cr_write_en && (cr_addr == ADDR_WIDTH'(4 * n + 1));
      wr_clr[n]  = cr_write_en && (cr_addr == ADDR_WIDTH'(4 * n + 2));
      rd_lo[n]   = cr_read_en  && (cr_addr == ADDR_WIDTH'(4 * n + 2));
      // Out-of-range selects never count
      inc[n]     = ctrl_en[n] && (32'(sel[n]) < NUM_EVENTS) && perf_events[sel[n]];
      // A clear in the same cycle suppresses the increment, so no wrap either
      wrap[n]    = inc[n] && !wr_clr[n] && (count[n][31:0] == 32'hFFFF_FFFF);
    end
  end

  // Read data multiplexer over pre-update register values
  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < NUM_COUNTERS; n++) begin
      if (cr_addr == ADDR_WIDTH'(4 * n))     rd_mux = 32'(sel[n]);
      if (cr_addr == ADDR_WIDTH'(4 * n + 1)) rd_mux = {30'd0, irq_en[n], ctrl_en[n]};
      if (cr_addr == ADDR_WIDTH'(4 * n + 2)) rd_mux = count[n][31:0];
      if (cr_addr == ADDR_WIDTH'(4 * n + 3)) rd_mux = snap_hi[n];
    end
    if (cr_addr == IRQ_ADDR) rd_mux = 32'(irq_status);
  end

  // Counters, configuration, snapshots and IRQ status
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      sel        <= '0;
      snap_hi    <= '0;
      ctrl_en    <= '0;
      irq_en     <= '0;
      irq_status <= '0;
    end else begin
      for (int n = 0; n < NUM_COUNTERS; n++) begin
        if (wr_clr[n])   count[n] <= '0;
        else if (inc[n]) count[n] <= count[n] + 64'd1;
        if (wr_sel[n]) sel[n] <= cr_write_data[EVENT_IDX_WIDTH-1:0];
        if (wr_ctrl[n]) begin
          ctrl_en[n] <= cr_write_data[0];
          irq_en[n]  <= cr_write_data[1];
        end
        // High word captured alongside the low-word read for a coherent 64-bit pair
        if (rd_lo[n]) snap_hi[n] <= count[n][63:32];
        // Wrap set has priority over a simultaneous write-1-to-clear
        if (wrap[n])                         irq_status[n] <= 1'b1;
        else if (wr_irq && cr_write_data[n]) irq_status[n] <= 1'b0;
      end
    end
  end

  // Registered read response; data holds between responses
  always_ff @(posedge clk) begin
    if (reset) begin
      cr_read_valid <= 1'b0;
      cr_read_data  <= '0;
    end else begin
      cr_read_valid <= cr_read_en;
      if (cr_read_en) cr_read_data <= rd_mux;
    end
  end

  // Interrupt output, one cycle behind status/enable changes
  always_ff @(posedge clk) begin
    if (reset) perf_irq <= 1'b0;
    else       perf_irq <= |(irq_status & irq_en);
  end

endmodule
